// File: rtl/i2c_target_if.sv
// I2C write-only target front end: decodes (register address, data word) pairs
// for the matrix-vector multiplier and hands them over with a valid/ack handshake.
module i2c_target_if #(
   parameter int         DATA_WIDTH  = 8,
   parameter int         VECTOR_SIZE = 4,
   parameter int         ADDR_WIDTH  = $clog2(2*VECTOR_SIZE + VECTOR_SIZE*VECTOR_SIZE),
   parameter logic [6:0] DEV_ADDR    = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_scl,
   input  logic                  i_sda,
   output logic                  o_sda_oe,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic [ADDR_WIDTH-1:0] o_addr_out,
   output logic                  o_valid,
   input  logic                  i_ack_in,
   output logic                  o_overrun,
   output logic                  o_busy
);

   localparam int NUM_ENTRIES = 2*VECTOR_SIZE + VECTOR_SIZE*VECTOR_SIZE;
   localparam int BYTES       = DATA_WIDTH / 8;
   localparam int BCW         = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] DEVADDR  = 3'd1;
   localparam logic [2:0] ACK_DEV  = 3'd2;
   localparam logic [2:0] REGADDR  = 3'd3;
   localparam logic [2:0] ACK_REG  = 3'd4;
   localparam logic [2:0] DATA     = 3'd5;
   localparam logic [2:0] ACK_DATA = 3'd6;
   localparam logic [2:0] IGNORE   = 3'd7;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_s, sda_s, scl_d, sda_d;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   logic [2:0]            state;
   logic [2:0]            bit_cnt;
   logic [BCW-1:0]        byte_cnt;
   logic [6:0]            shift_reg;
   logic [DATA_WIDTH-2:0] word_sr;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [7:0]            next_byte;
   logic [DATA_WIDTH-1:0] next_word;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   always_comb begin
      scl_s     = scl_sync[SYNC_STAGES-1];
      sda_s     = sda_sync[SYNC_STAGES-1];
      scl_rise  = scl_s & ~scl_d;
      scl_fall  = ~scl_s & scl_d;
      start_det = scl_s & scl_d & sda_d & ~sda_s;
      stop_det  = scl_s & scl_d & ~sda_d & sda_s;
      next_byte = {shift_reg, sda_s};
      next_word = {word_sr, sda_s};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         shift_reg  <= '0;
         word_sr    <= '0;
         addr_cnt   <= '0;
         o_sda_oe   <= 1'b0;
         o_data_out <= '0;
         o_addr_out <= '0;
         o_valid    <= 1'b0;
         o_overrun  <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         if (o_valid && i_ack_in)
            o_valid <= 1'b0;

         if (start_det) begin
            state    <= DEVADDR;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            word_sr  <= '0;
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b1;
         end else if (stop_det) begin
            state    <= IDLE;
            byte_cnt <= '0;
            word_sr  <= '0;
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b0;
         end else if (state == DEVADDR || state == REGADDR || state == DATA) begin
            if (scl_rise) begin
               shift_reg <= next_byte[6:0];
               bit_cnt   <= bit_cnt + 3'd1;
               if (state == DATA)
                  word_sr <= next_word[DATA_WIDTH-2:0];
               if (bit_cnt == 3'd7) begin
                  if (state == DEVADDR) begin
                     state <= (next_byte[7:1] == DEV_ADDR && !next_byte[0]) ? ACK_DEV : IGNORE;
                  end else if (state == REGADDR) begin
                     if (32'(next_byte) < 32'(NUM_ENTRIES)) begin
                        addr_cnt <= ADDR_WIDTH'(next_byte);
                        state    <= ACK_REG;
                     end else begin
                        state <= IGNORE;
                     end
                  end else if (byte_cnt != BCW'(BYTES-1)) begin
                     byte_cnt <= byte_cnt + BCW'(1);
                     state    <= ACK_DATA;
                  end else begin
                     byte_cnt <= '0;
                     // Acking in the same cycle frees the holding register for this word.
                     if (!o_valid || i_ack_in) begin
                        o_data_out <= next_word;
                        o_addr_out <= addr_cnt;
                        o_valid    <= 1'b1;
                        addr_cnt   <= (addr_cnt == ADDR_WIDTH'(NUM_ENTRIES-1)) ? '0 : addr_cnt + ADDR_WIDTH'(1);
                        state      <= ACK_DATA;
                     end else begin
                        o_overrun <= 1'b1;
                        state     <= IGNORE;
                     end
                  end
               end
            end
         end else if (state == ACK_DEV || state == ACK_REG || state == ACK_DATA) begin
            // First falling edge (8th) starts the ACK, the next one (9th) ends it.
            if (scl_fall) begin
               if (!o_sda_oe) begin
                  o_sda_oe <= 1'b1;
               end else begin
                  o_sda_oe <= 1'b0;
                  bit_cnt  <= '0;
                  state    <= (state == ACK_DEV) ? REGADDR : DATA;
               end
            end
         end
      end
   end

endmodule
